// File: rtl/dp_pkg.sv
// Shared types and constants for the dot-product controller.
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int OP_W    = 4;
  localparam int PROD_W  = 8;
  localparam int MUL_LAT = 4;

endpackage

// File: rtl/dot_product_ctrl_if.sv
// Operand stream, multiplier link and result port of the dot-product controller.
interface dot_product_ctrl_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) ();

  logic                        in_valid_i;
  logic                        in_ready_o;
  logic [dp_pkg::OP_W-1:0]     in_a_i;
  logic [dp_pkg::OP_W-1:0]     in_b_i;
  logic                        in_last_i;

  logic                        mul_start_o;
  logic [dp_pkg::OP_W-1:0]     mul_a_o;
  logic [dp_pkg::OP_W-1:0]     mul_b_o;
  logic                        mul_busy_i;
  logic                        mul_valid_i;
  logic [dp_pkg::PROD_W-1:0]   mul_result_i;

  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [ACC_W-1:0]            out_sum_o;
  logic [CNT_W-1:0]            out_terms_o;
  logic                        out_ovf_o;

  // slave = the controller; master = whatever drives pairs, multiplier results and out_ready
  modport slave (
    input  in_valid_i, in_a_i, in_b_i, in_last_i,
    input  mul_busy_i, mul_valid_i, mul_result_i,
    input  out_ready_i,
    output in_ready_o, mul_start_o, mul_a_o, mul_b_o,
    output out_valid_o, out_sum_o, out_terms_o, out_ovf_o
  );

  modport master (
    output in_valid_i, in_a_i, in_b_i, in_last_i,
    output mul_busy_i, mul_valid_i, mul_result_i,
    output out_ready_i,
    input  in_ready_o, mul_start_o, mul_a_o, mul_b_o,
    input  out_valid_o, out_sum_o, out_terms_o, out_ovf_o
  );

endinterface

// File: rtl/dot_product_ctrl_sat_acc.sv
// Saturating accumulator: sticks at all-ones on carry and flags it until cleared.
module sat_acc #(
  parameter int W    = 16,
  parameter int IN_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [IN_W-1:0] add_i,
  output logic [W-1:0]    sum_o,
  output logic            ovf_o
);

  logic [W-1:0] sum_q, sum_d;
  logic         ovf_q, ovf_d;
  logic [W:0]   ext;

  always_comb begin
    ext   = {1'b0, sum_q} + {{(W + 1 - IN_W){1'b0}}, add_i};
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      sum_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      if (ext[W]) begin
        sum_d = '1;
        ovf_d = 1'b1;
      end else begin
        sum_d = ext[W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum_o = sum_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/dot_product_ctrl.sv
// Sequences operand pairs into the shift-add multiplier and collects a saturated dot product.
//  state | meaning
//  IDLE  | ready for the next operand pair
//  ISSUE | start pulse to the multiplier (held off while it is busy)
//  WAIT  | waiting for the product, then accumulate
//  OUT   | dot product presented until the consumer takes it
module dot_product_ctrl
  import dp_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input logic               clk_i,
  input logic               rst_i,
  dot_product_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   a_q, b_q;
  logic              last_q;
  logic [CNT_W-1:0]  terms_q, terms_d;
  logic              take_in, acc_en, acc_clr;
  logic [ACC_W-1:0]  sum;
  logic              ovf;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.in_valid_i)   state_d = ISSUE;
      ISSUE: if (!bus.mul_busy_i)  state_d = WAIT;
      // mul_valid_i seen in ISSUE may be the previous product, so only WAIT listens
      WAIT:  if (bus.mul_valid_i)  state_d = last_q ? OUT : IDLE;
      OUT:   if (bus.out_ready_i)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready_o  = (state_q == IDLE);
    bus.mul_start_o = (state_q == ISSUE) && !bus.mul_busy_i;
    bus.out_valid_o = (state_q == OUT);
    take_in         = (state_q == IDLE) && bus.in_valid_i;
    acc_en          = (state_q == WAIT) && bus.mul_valid_i;
    acc_clr         = (state_q == OUT)  && bus.out_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      last_q <= 1'b0;
    end else if (take_in) begin
      a_q    <= bus.in_a_i;
      b_q    <= bus.in_b_i;
      last_q <= bus.in_last_i;
    end
  end

  always_comb begin
    terms_d = terms_q;
    if (acc_clr)                     terms_d = '0;
    else if (acc_en && terms_q != '1) terms_d = terms_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) terms_q <= '0;
    else       terms_q <= terms_d;
  end

  sat_acc #(
    .W    (ACC_W),
    .IN_W (PROD_W)
  ) u_acc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .add_i (bus.mul_result_i),
    .sum_o (sum),
    .ovf_o (ovf)
  );

  assign bus.mul_a_o     = a_q;
  assign bus.mul_b_o     = b_q;
  assign bus.out_sum_o   = sum;
  assign bus.out_terms_o = terms_q;
  assign bus.out_ovf_o   = ovf;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench for dot_product_ctrl with a behavioural 4-cycle multiplier and a min()-based sum model.
module tb_dot_product_ctrl;
  import dp_pkg::*;

  localparam int ACC_W   = 10;
  localparam int CNT_W   = 3;
  localparam int SUM_MAX = (1 << ACC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_product_ctrl_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  dot_product_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // multiplier: busy for MUL_LAT cycles after start, product held valid until the next start
  int mcnt;
  always @(posedge clk) begin
    if (rst) begin
      bus.mul_busy_i   <= 1'b0;
      bus.mul_valid_i  <= 1'b0;
      bus.mul_result_i <= '0;
      mcnt             <= 0;
    end else if (bus.mul_start_o) begin
      bus.mul_busy_i  <= 1'b1;
      bus.mul_valid_i <= 1'b0;
      mcnt            <= MUL_LAT - 1;
    end else if (bus.mul_busy_i) begin
      if (mcnt == 0) begin
        bus.mul_busy_i   <= 1'b0;
        bus.mul_valid_i  <= 1'b1;
        bus.mul_result_i <= 8'(bus.mul_a_o) * 8'(bus.mul_b_o);
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int qa[$];
  int qb[$];

  task automatic chk_idle_clear(input string tag);
    chk({tag, "_ready"}, 32'(bus.in_ready_o), 32'd1);
    chk({tag, "_oval"},  32'(bus.out_valid_o), 32'd0);
    chk({tag, "_sum"},   32'(bus.out_sum_o), 32'd0);
    chk({tag, "_terms"}, 32'(bus.out_terms_o), 32'd0);
    chk({tag, "_ovf"},   32'(bus.out_ovf_o), 32'd0);
    chk({tag, "_start"}, 32'(bus.mul_start_o), 32'd0);
  endtask

  // one accepted pair: checks the 7-cycle cadence and operand stability
  task automatic issue_pair(input int a, input int b, input bit last, input bit noise);
    chk("idle_ready", 32'(bus.in_ready_o), 32'd1);
    bus.in_a_i      = 4'(a);
    bus.in_b_i      = 4'(b);
    bus.in_last_i   = last;
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    for (int c = 1; c <= 6; c++) begin
      if (noise) begin
        bus.in_valid_i  = 1'($urandom_range(0, 1));
        bus.in_a_i      = 4'($urandom_range(0, 15));
        bus.in_b_i      = 4'($urandom_range(0, 15));
        bus.in_last_i   = 1'($urandom_range(0, 1));
        bus.out_ready_i = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid_i = 1'b0;
      end
      chk("busy_ready", 32'(bus.in_ready_o), 32'd0);
      chk("start",      32'(bus.mul_start_o), 32'(c == 1));
      chk("mul_a",      32'(bus.mul_a_o), 32'(a));
      chk("mul_b",      32'(bus.mul_b_o), 32'(b));
      chk("oval_early", 32'(bus.out_valid_o), 32'd0);
      tick();
    end
  endtask

  task automatic run_vec(input int hold, input bit noise);
    int     n;
    longint acc;
    int     exp_sum, exp_terms;
    n   = qa.size();
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) chk("oval_mid", 32'(bus.out_valid_o), 32'd0);
      issue_pair(qa[i], qb[i], (i == n - 1), noise);
      acc += longint'(qa[i] * qb[i]);
    end
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = (hold > 0);
    exp_sum   = (acc > SUM_MAX) ? SUM_MAX : int'(acc);
    exp_terms = (n > CNT_MAX) ? CNT_MAX : n;
    chk("oval",  32'(bus.out_valid_o), 32'd1);
    chk("sum",   32'(bus.out_sum_o), 32'(exp_sum));
    chk("terms", 32'(bus.out_terms_o), 32'(exp_terms));
    chk("ovf",   32'(bus.out_ovf_o), 32'(acc > SUM_MAX));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_oval",  32'(bus.out_valid_o), 32'd1);
      chk("hold_sum",   32'(bus.out_sum_o), 32'(exp_sum));
      chk("hold_terms", 32'(bus.out_terms_o), 32'(exp_terms));
      chk("hold_ready", 32'(bus.in_ready_o), 32'd0);
      chk("hold_start", 32'(bus.mul_start_o), 32'd0);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    chk_idle_clear("post");
    qa.delete();
    qb.delete();
  endtask

  task automatic push(input int a, input int b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_a_i      = '0;
    bus.in_b_i      = '0;
    bus.in_last_i   = 1'b0;
    bus.out_ready_i = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_idle_clear("reset");
    chk("reset_mul_a", 32'(bus.mul_a_o), 32'd0);

    push(3, 5);
    run_vec(0, 1'b0);

    for (int i = 0; i < 4; i++) push(15, 15);
    run_vec(0, 1'b0);

    for (int i = 0; i < 5; i++) push(15, 15);
    run_vec(0, 1'b0);
    push(2, 2);
    run_vec(0, 1'b0);

    push(6, 7);
    push(4, 3);
    run_vec(10, 1'b0);

    // reset while the second term is in the multiplier
    issue_pair(15, 15, 1'b0, 1'b0);
    bus.in_a_i     = 4'd9;
    bus.in_b_i     = 4'd9;
    bus.in_last_i  = 1'b0;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_clear("midrst");
    chk("midrst_mul_a", 32'(bus.mul_a_o), 32'd0);
    push(1, 7);
    run_vec(0, 1'b0);

    push(0, 7);
    push(9, 0);
    push(1, 1);
    run_vec(0, 1'b0);

    for (int i = 0; i < 9; i++) push(1, 2);
    run_vec(0, 1'b0);

    for (int v = 0; v < 12; v++) begin
      int n;
      bit big;
      n   = $urandom_range(1, 9);
      big = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        if (big) push($urandom_range(10, 15), $urandom_range(10, 15));
        else     push($urandom_range(0, 15), $urandom_range(0, 15));
      end
      run_vec($urandom_range(0, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
